// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ifu_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// rtl/instr_fetch_unit_fifo.sv - prefetch queue holding {pc, instr} pairs, flush beats push/pop
module ifu_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage write; a slot written during a flush is simply never read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue regardless of push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, IM request FSM and prefetch queue front end (option: IFU_PERF_CNT_EN)
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              IM_REQ,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic              IM_ACK,
    input  logic [31:0]       IM_Q,
    output logic [31:0]       INSTRUCTION,
    output logic [31:0]       INSTR_PC,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    input  logic              REDIRECT,
    input  logic [31:0]       NEXT_PC
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       FETCH_CNT,
    output logic [31:0]       FLUSH_CNT
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifu_state_t       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_after;
    logic [31:0]      instr_pc_q;
    logic [63:0]      head_data;
    logic [31:0]      head_pc;
    logic [31:0]      head_instr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             credit_after;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    // In REQ the outstanding request is always for fetch_pc; a redirect discards its data
    assign push = (state == REQ) && IM_ACK && !REDIRECT;
    assign pop  = !empty && INSTR_READY;

    ifu_fifo #(.DEPTH(DEPTH), .W(64), .CNT_W(CNT_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({fetch_pc, IM_Q}),
        .pop       (pop),
        .flush     (REDIRECT),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign head_pc     = head_data[63:32];
    assign head_instr  = head_data[31:0];
    assign INSTR_VALID = !empty;
    assign INSTRUCTION = empty ? NOP_INSTR : head_instr;
    assign INSTR_PC    = empty ? instr_pc_q : head_pc;

    // Next fetch address and whether another request fits after this cycle's push/pop
    always_comb begin
        pc_after = fetch_pc;
        if (REDIRECT) begin
            pc_after = align_pc(NEXT_PC);
        end else if (push) begin
            pc_after = fetch_pc + PC_STEP;
        end
        count_after  = count + CNT_W'(push) - CNT_W'(pop);
        credit_after = (count_after < CNT_W'(DEPTH));
    end

    // Fetch FSM with registered request outputs held stable until acknowledged
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            IM_REQ   <= 1'b0;
            IM_ADDR  <= RESET_PC[ADDR_W+1:2];
        end else begin
            fetch_pc <= pc_after;
            unique case (state)
                IDLE: begin
                    if (!REDIRECT && !full) begin
                        state   <= REQ;
                        IM_REQ  <= 1'b1;
                        IM_ADDR <= pc_after[ADDR_W+1:2];
                    end
                end
                REQ: begin
                    if (REDIRECT && !IM_ACK) begin
                        state <= DRAIN;
                    end else if (IM_ACK) begin
                        IM_ADDR <= pc_after[ADDR_W+1:2];
                        if (!REDIRECT && !credit_after) begin
                            state  <= IDLE;
                            IM_REQ <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (IM_ACK) begin
                        state   <= REQ;
                        IM_ADDR <= pc_after[ADDR_W+1:2];
                    end
                end
                default: begin
                    state  <= IDLE;
                    IM_REQ <= 1'b0;
                end
            endcase
        end
    end

    // Last presented PC, shown again while the queue is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_pc_q <= 32'h0;
        end else if (!empty) begin
            instr_pc_q <= head_pc;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic drain_discard;
    assign drain_discard = (state == DRAIN) && IM_ACK;

    // Fetched-word and flush-event counters, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            FETCH_CNT <= 32'h0;
            FLUSH_CNT <= 32'h0;
        end else begin
            FETCH_CNT <= FETCH_CNT + 32'(push);
            FLUSH_CNT <= FLUSH_CNT + 32'(REDIRECT) + 32'(drain_discard);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized checks of instr_fetch_unit against a stream model
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IM_REQ;
    logic [15:0] IM_ADDR;
    logic        IM_ACK = 1'b0;
    logic [31:0] IM_Q = 32'h0;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] NEXT_PC = 32'h0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] FETCH_CNT;
    logic [31:0] FLUSH_CNT;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(16), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .IM_REQ      (IM_REQ),
        .IM_ADDR     (IM_ADDR),
        .IM_ACK      (IM_ACK),
        .IM_Q        (IM_Q),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .REDIRECT    (REDIRECT),
        .NEXT_PC     (NEXT_PC)
`ifdef IFU_PERF_CNT_EN
        ,
        .FETCH_CNT   (FETCH_CNT),
        .FLUSH_CNT   (FLUSH_CNT)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;

    bit          k_rst = 1'b1;
    bit          k_ready = 1'b0;
    bit          k_redir = 1'b0;
    logic [31:0] k_npc = 32'h0;
    int          ack_wait = 0;
    int          waited = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_pc = 32'h0;
    bit          stale = 1'b0;
    bit          hold_pending = 1'b0;
    logic [15:0] hold_addr = 16'h0;
    bit          after_rst = 1'b0;
    bit          started = 1'b0;
    int          n_acks = 0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_flush = 32'h0;
    logic [15:0] addr0;
    logic [31:0] wexp;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {14'b0, pc[17:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req_v);
        n_vec++;
        assert (obs === req_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req_v);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (started) begin
            if (after_rst) chk("rst_req_drop", IM_REQ, 1'b0);
            chk("valid", INSTR_VALID, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("head_pc", INSTR_PC, mq[0]);
                chk("head_instr", INSTRUCTION, word_at(mq[0]));
            end else begin
                chk("empty_nop", INSTRUCTION, 32'h0);
            end
            chk("credit", (mq.size() + int'(IM_REQ)) <= DEPTH, 1'b1);
            if (hold_pending) begin
                chk("hold_req", IM_REQ, 1'b1);
                chk("hold_addr", IM_ADDR, hold_addr);
            end
`ifdef IFU_PERF_CNT_EN
            chk("fetch_cnt", FETCH_CNT, m_fetch);
            chk("flush_cnt", FLUSH_CNT, m_flush);
`endif
        end
    endtask

    task automatic drive();
        bit ack;
        bit discard;
        rst         = k_rst;
        INSTR_READY = k_ready;
        REDIRECT    = k_redir;
        NEXT_PC     = k_npc;
        ack = 1'b0;
        if (!k_rst && IM_REQ === 1'b1) begin
            if (waited >= ack_wait) begin
                ack = 1'b1;
                waited = 0;
            end else begin
                waited++;
            end
        end else begin
            waited = 0;
        end
        IM_ACK = ack;
        IM_Q   = {14'b0, IM_ADDR, 2'b00};
        started = 1'b1;
        if (k_rst) begin
            mq.delete();
            exp_pc = 32'h0;
            stale = 1'b0;
            hold_pending = 1'b0;
            after_rst = 1'b1;
            m_fetch = 32'h0;
            m_flush = 32'h0;
        end else begin
            after_rst = 1'b0;
            if (mq.size() != 0 && k_ready) void'(mq.pop_front());
            if (IM_REQ && ack) begin
                discard = k_redir || stale;
                if (stale) m_flush++;
                if (!discard) begin
                    chk("fetch_addr", IM_ADDR, exp_pc[17:2]);
                    mq.push_back(exp_pc);
                    exp_pc += 32'd4;
                    m_fetch++;
                    n_acks++;
                    chk("no_overflow", mq.size() <= DEPTH, 1'b1);
                end
                stale = 1'b0;
            end else if (IM_REQ && k_redir) begin
                stale = 1'b1;
            end
            if (k_redir) begin
                mq.delete();
                exp_pc = k_npc & ~32'h3;
                m_flush++;
            end
            hold_pending = IM_REQ && !ack;
            hold_addr    = IM_ADDR;
        end
    endtask

    task automatic cycle();
        sample();
        drive();
    endtask

    task automatic do_reset();
        k_rst = 1'b1;
        k_redir = 1'b0;
        cycle();
        cycle();
        k_rst = 1'b0;
    endtask

    initial begin
        // Reset state and T1 zero-wait streaming
        ack_wait = 0;
        do_reset();
        k_ready = 1'b1;
        sample();
        chk("rst_req", IM_REQ, 1'b0);
        chk("rst_valid", INSTR_VALID, 1'b0);
        chk("rst_instr", INSTRUCTION, 32'h0);
        chk("rst_pc", INSTR_PC, 32'h0);
        chk("rst_addr", IM_ADDR, 16'h0);
        drive();
        sample();
        chk("t1_req", IM_REQ, 1'b1);
        chk("t1_addr", IM_ADDR, 16'h0);
        chk("t1_not_yet", INSTR_VALID, 1'b0);
        drive();
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t1_valid", INSTR_VALID, 1'b1);
            chk("t1_pc", INSTR_PC, 32'(i * 4));
            drive();
        end

        // T2 consumer stalled: queue fills to DEPTH, then drains back-to-back
        do_reset();
        k_ready = 1'b0;
        n_acks = 0;
        repeat (10) cycle();
        chk("t2_acks", n_acks, DEPTH);
        sample();
        chk("t2_req_idle", IM_REQ, 1'b0);
        chk("t2_pc0", INSTR_PC, 32'h0);
        k_ready = 1'b1;
        drive();
        for (int i = 1; i < 4; i++) begin
            sample();
            chk("t2_valid", INSTR_VALID, 1'b1);
            chk("t2_pc", INSTR_PC, 32'(i * 4));
            drive();
        end

        // T3 jump while queue holds three entries
        do_reset();
        k_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (mq.size() == 3) break;
            drive();
        end
        chk("t3_fill", mq.size(), 3);
        k_redir = 1'b1;
        k_npc = 32'h0000_00A8;
        drive();
        k_redir = 1'b0;
        sample();
        chk("t3_flush", INSTR_VALID, 1'b0);
        chk("t3_req", IM_REQ, 1'b1);
        chk("t3_addr", IM_ADDR, 16'd42);
        k_ready = 1'b1;
        drive();
        sample();
        chk("t3_lat_valid", INSTR_VALID, 1'b1);
        chk("t3_first_pc", INSTR_PC, 32'hA8);
        drive();

        // T4 slow memory, redirect during the first wait cycle
        do_reset();
        ack_wait = 3;
        k_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (IM_REQ === 1'b1) break;
            drive();
        end
        chk("t4_req_seen", IM_REQ, 1'b1);
        addr0 = IM_ADDR;
        k_redir = 1'b1;
        k_npc = 32'h0000_0060;
        drive();
        k_redir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t4_hold_req", IM_REQ, 1'b1);
            chk("t4_hold_addr", IM_ADDR, addr0);
            chk("t4_no_stale", INSTR_VALID, 1'b0);
            drive();
        end
        sample();
        chk("t4_new_req", IM_REQ, 1'b1);
        chk("t4_new_addr", IM_ADDR, 16'd24);
        chk("t4_no_stale", INSTR_VALID, 1'b0);
        ack_wait = 0;
        drive();
        sample();
        chk("t4_first_pc", INSTR_PC, 32'h60);
        drive();

        // T5 redirect and ACK in the same cycle, unaligned target
        do_reset();
        k_ready = 1'b1;
        repeat (6) cycle();
        sample();
        chk("t5_req", IM_REQ, 1'b1);
        k_redir = 1'b1;
        k_npc = 32'h0000_0003;
        drive();
        k_redir = 1'b0;
        sample();
        chk("t5_addr", IM_ADDR, 16'h0);
        chk("t5_dropped", INSTR_VALID, 1'b0);
        drive();
        sample();
        chk("t5_valid", INSTR_VALID, 1'b1);
        chk("t5_pc", INSTR_PC, 32'h0);
        drive();

        // PC wrap through the top of the address space
        sample();
        k_redir = 1'b1;
        k_npc = 32'hFFFF_FFF8;
        drive();
        k_redir = 1'b0;
        sample();
        chk("wrap_addr", IM_ADDR, 16'hFFFE);
        drive();
        for (int i = 0; i < 4; i++) begin
            sample();
            wexp = 32'hFFFF_FFF8 + 32'(i * 4);
            chk("wrap_pc", INSTR_PC, wexp);
            drive();
        end

`ifdef IFU_PERF_CNT_EN
        // T6 counters: eight pops, one redirect, then reset mid-run
        do_reset();
        k_ready = 1'b1;
        repeat (10) cycle();
        sample();
        k_redir = 1'b1;
        k_npc = 32'h100;
        drive();
        k_redir = 1'b0;
        sample();
        chk("t6_fetch_ge8", FETCH_CNT >= 32'd8, 1'b1);
        chk("t6_flush", FLUSH_CNT, 32'd1);
        drive();
        repeat (3) cycle();
        sample();
        k_rst = 1'b1;
        drive();
        k_rst = 1'b0;
        sample();
        chk("t6_fetch_clr", FETCH_CNT, 32'h0);
        chk("t6_flush_clr", FLUSH_CNT, 32'h0);
        chk("t6_req_drop", IM_REQ, 1'b0);
        drive();
`endif

        // Randomized traffic: stalls, redirects, variable memory latency, occasional reset
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            sample();
            k_ready = ($urandom_range(0, 9) < 7);
            k_redir = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) k_npc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else k_npc = $urandom;
            k_rst = ($urandom_range(0, 299) == 0);
            if (waited == 0) ack_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            drive();
        end
        k_rst = 1'b0;
        k_redir = 1'b0;
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
